// File: rtl/tcp_pkg.sv
// Shared types for the TCP handshake endpoints: FSM states,
// flag bit positions and the segment bundle.
package tcp_pkg;

   typedef enum logic [2:0] {
      CLOSED      = 3'd0,
      SYN_SENT    = 3'd1,
      ESTABLISHED = 3'd2,
      FIN_WAIT    = 3'd3,
      FAILED      = 3'd4
   } tcp_state_t;

   localparam int FLAG_SYN = 0;
   localparam int FLAG_ACK = 1;
   localparam int FLAG_FIN = 2;

   localparam logic [2:0] SEG_SYN = 3'b001;
   localparam logic [2:0] SEG_ACK = 3'b010;
   localparam logic [2:0] SEG_FIN = 3'b100;

   localparam int SEQ_W_MAX = 32;

   typedef struct packed {
      logic [2:0]           flags;
      logic [SEQ_W_MAX-1:0] seq;
      logic [SEQ_W_MAX-1:0] ack;
   } tcp_seg_t;

endpackage

// File: rtl/tcp_retry_timer.sv
// Response timer plus bounded retry counter, shared by the
// client and server handshake endpoints.
module tcp_retry_timer #(
   parameter int TIMEOUT   = 16,
   parameter int MAX_RETRY = 3
) (
   input  logic clock,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expire,
   output logic exhausted
);

   localparam int TW = $clog2(TIMEOUT);
   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

   logic [TW-1:0] timer;
   logic [RW-1:0] retry;

   assign expire    = run && (timer == T_LAST);
   assign exhausted = (retry == R_MAX);

   always_ff @(posedge clock) begin
      if (rst || clear) begin
         timer <= '0;
         retry <= '0;
      end else if (run) begin
         if (expire) begin
            timer <= '0;
            if (!exhausted) retry <= retry + 1'b1;
         end else begin
            timer <= timer + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tcp_client_endpoint.sv
// Client-side SYN/SYN_ACK/ACK handshake with FIN teardown.
// Define TCP_CLIENT_RETRY_EN for timeout retransmission and FAILED.
module tcp_client_endpoint #(
   parameter int               SEQ_W     = 8,
   parameter logic [SEQ_W-1:0] ISN       = 8'h10,
   parameter int               TIMEOUT   = 16,
   parameter int               MAX_RETRY = 3
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             Control,
   input  logic             Close,
   input  logic             rx_valid,
   input  logic [2:0]       rx_flags,
   input  logic [SEQ_W-1:0] rx_seq,
   input  logic [SEQ_W-1:0] rx_ack,
   output logic             tx_valid,
   output logic [2:0]       tx_flags,
   output logic [SEQ_W-1:0] tx_seq,
   output logic [SEQ_W-1:0] tx_ack,
   output logic [2:0]       state,
   output logic             established,
   output logic             error
);
   import tcp_pkg::*;

   localparam logic [SEQ_W-1:0] ONE    = SEQ_W'(1);
   localparam logic [SEQ_W-1:0] ISN_P1 = ISN + ONE;
   localparam logic [SEQ_W-1:0] ISN_P2 = ISN_P1 + ONE;

   tcp_state_t       state_q, state_n;
   logic [SEQ_W-1:0] peer_q, peer_n;
   logic             txv_n;
   logic [2:0]       flags_n;
   logic [SEQ_W-1:0] seq_n, ack_n;
   logic             est_q;
   logic             expire, exhausted, tmr_clear, tmr_run;
   logic             syn_ack_ok, fin_in, fin_ack_ok;

   assign syn_ack_ok = rx_valid && rx_flags[FLAG_SYN] && rx_flags[FLAG_ACK]
                       && (rx_ack == ISN_P1);
   assign fin_in     = rx_valid && rx_flags[FLAG_FIN];
   assign fin_ack_ok = rx_valid && rx_flags[FLAG_ACK] && (rx_ack == ISN_P2);
   assign tmr_run    = (state_q == SYN_SENT) || (state_q == FIN_WAIT);

   always_comb begin
      state_n   = state_q;
      peer_n    = peer_q;
      txv_n     = 1'b0;
      flags_n   = tx_flags;
      seq_n     = tx_seq;
      ack_n     = tx_ack;
      tmr_clear = 1'b0;
      unique case (state_q)
         CLOSED: begin
            if (Control) begin
               txv_n     = 1'b1;
               flags_n   = SEG_SYN;
               seq_n     = ISN;
               ack_n     = '0;
               tmr_clear = 1'b1;
               state_n   = SYN_SENT;
            end
         end
         SYN_SENT: begin
            if (syn_ack_ok) begin
               peer_n  = rx_seq;
               txv_n   = 1'b1;
               flags_n = SEG_ACK;
               seq_n   = ISN_P1;
               ack_n   = rx_seq + ONE;
               state_n = ESTABLISHED;
            end else if (expire) begin
               if (exhausted) state_n = FAILED;
               else           txv_n   = 1'b1;
            end
         end
         ESTABLISHED: begin
            if (fin_in) begin
               txv_n   = 1'b1;
               flags_n = SEG_ACK;
               seq_n   = ISN_P1;
               ack_n   = rx_seq + ONE;
               state_n = CLOSED;
            end else if (Close) begin
               txv_n     = 1'b1;
               flags_n   = SEG_FIN;
               seq_n     = ISN_P1;
               ack_n     = peer_q + ONE;
               tmr_clear = 1'b1;
               state_n   = FIN_WAIT;
            end
         end
         FIN_WAIT: begin
            if (fin_ack_ok) begin
               state_n = CLOSED;
            end else if (expire) begin
               if (exhausted) state_n = FAILED;
               else           txv_n   = 1'b1;
            end
         end
         FAILED: begin
            if (!Control) state_n = CLOSED;
         end
         default: state_n = CLOSED;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q  <= CLOSED;
         peer_q   <= '0;
         tx_valid <= 1'b0;
         tx_flags <= '0;
         tx_seq   <= '0;
         tx_ack   <= '0;
         est_q    <= 1'b0;
      end else begin
         state_q  <= state_n;
         peer_q   <= peer_n;
         tx_valid <= txv_n;
         tx_flags <= flags_n;
         tx_seq   <= seq_n;
         tx_ack   <= ack_n;
         est_q    <= (state_n == ESTABLISHED);
      end
   end

   assign state       = state_q;
   assign established = est_q;

`ifdef TCP_CLIENT_RETRY_EN
   logic err_q;

   tcp_retry_timer #(
      .TIMEOUT   (TIMEOUT),
      .MAX_RETRY (MAX_RETRY)
   ) u_timer (
      .clock     (clock),
      .rst       (rst),
      .clear     (tmr_clear),
      .run       (tmr_run),
      .expire    (expire),
      .exhausted (exhausted)
   );

   always_ff @(posedge clock) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= (state_n == FAILED);
   end

   assign error = err_q;
`else
   logic unused_tmr;

   assign expire     = 1'b0;
   assign exhausted  = 1'b0;
   assign unused_tmr = tmr_clear ^ tmr_run;
   assign error      = 1'b0;
`endif

endmodule
